// File: rtl/call_return_seq.sv
// call_return_seq
//   Program-counter sequencer that drives a return-address stack (the
//   initiator side of the push/pop interface). Decodes CALL / RET / JMP when
//   the decoder strobes step, issues one-cycle push/pop strobes, tracks the
//   stack depth locally and traps overflow/underflow into a HALT state.
//
// Parameters
//   ADDR_W  width of pc, call/jump target and stack data
//   DEPTH   stack capacity; must match the attached stack
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   step              execute the current flow op this cycle
//   is_call/is_ret/is_jmp  op decode, priority call > ret > jmp
//   target            call/jump destination
//   stk_rdata         top-of-stack data, valid the cycle after stk_pop
//   pc                current program counter
//   stk_push/stk_pop  one-cycle strobes to the stack
//   stk_wdata         return address, valid while stk_push=1
//   depth             entries currently on the stack
//   busy              return in flight; step is dropped
//   ovf_err/unf_err   sticky overflow / underflow traps
module call_return_seq #(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 8,
  localparam int DW    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step,
  input  logic              is_call,
  input  logic              is_ret,
  input  logic              is_jmp,
  input  logic [ADDR_W-1:0] target,
  input  logic [ADDR_W-1:0] stk_rdata,
  output logic [ADDR_W-1:0] pc,
  output logic              stk_push,
  output logic              stk_pop,
  output logic [ADDR_W-1:0] stk_wdata,
  output logic [DW-1:0]     depth,
  output logic              busy,
  output logic              ovf_err,
  output logic              unf_err
);

  localparam logic [DW-1:0]     FULL     = DW'(DEPTH);
  localparam logic [DW-1:0]     D_ONE    = 1;
  localparam logic [ADDR_W-1:0] PC_ONE   = 1;

  typedef enum logic [1:0] {IDLE, POP_REQ, POP_WAIT, HALT} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic                push_q, push_d;
  logic                pop_q, pop_d;
  logic [ADDR_W-1:0]   wdata_q, wdata_d;
  logic [DW-1:0]       depth_q, depth_d;
  logic                busy_q, busy_d;
  logic                ovf_q, ovf_d;
  logic                unf_q, unf_d;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push_d  = 1'b0;   // strobes are single-cycle by construction
    pop_d   = 1'b0;
    wdata_d = wdata_q;
    depth_d = depth_q;
    busy_d  = busy_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;

    case (state_q)
      IDLE: begin
        if (step) begin
          if (is_call) begin
            if (depth_q == FULL) begin
              ovf_d   = 1'b1;
              state_d = HALT;
            end else begin
              push_d  = 1'b1;
              wdata_d = pc_q + PC_ONE;
              pc_d    = target;
              depth_d = depth_q + D_ONE;
            end
          end else if (is_ret) begin
            if (depth_q == '0) begin
              unf_d   = 1'b1;
              state_d = HALT;
            end else begin
              // depth drops as the pop is issued so it always mirrors the stack
              pop_d   = 1'b1;
              busy_d  = 1'b1;
              depth_d = depth_q - D_ONE;
              state_d = POP_REQ;
            end
          end else if (is_jmp) begin
            pc_d = target;
          end else begin
            pc_d = pc_q + PC_ONE;
          end
        end
      end
      // stack pops on this edge; its read data is stable during POP_WAIT
      POP_REQ:  state_d = POP_WAIT;
      POP_WAIT: begin
        pc_d    = stk_rdata;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      HALT:     state_d = HALT;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
      push_q  <= 1'b0;
      pop_q   <= 1'b0;
      wdata_q <= '0;
      depth_q <= '0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      push_q  <= push_d;
      pop_q   <= pop_d;
      wdata_q <= wdata_d;
      depth_q <= depth_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign pc        = pc_q;
  assign stk_push  = push_q;
  assign stk_pop   = pop_q;
  assign stk_wdata = wdata_q;
  assign depth     = depth_q;
  assign busy      = busy_q;
  assign ovf_err   = ovf_q;
  assign unf_err   = unf_q;

endmodule

// File: tb/tb_call_return_seq.sv
// Testbench for call_return_seq: directed scenarios plus a randomized run
// checked against a queue-based model of call/return semantics. A small
// behavioural stack sits on the push/pop interface and answers pops.
module tb_call_return_seq;
  localparam int ADDR_W = 12;
  localparam int DEPTH  = 8;
  localparam int DW     = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              step, is_call, is_ret, is_jmp;
  logic [ADDR_W-1:0] target, stk_rdata;
  logic [ADDR_W-1:0] pc, stk_wdata;
  logic              stk_push, stk_pop, busy, ovf_err, unf_err;
  logic [DW-1:0]     depth;

  int checks = 0;
  int errors = 0;

  call_return_seq #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .step(step), .is_call(is_call), .is_ret(is_ret),
    .is_jmp(is_jmp), .target(target), .stk_rdata(stk_rdata), .pc(pc),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_wdata(stk_wdata),
    .depth(depth), .busy(busy), .ovf_err(ovf_err), .unf_err(unf_err)
  );

  always #5 clk = ~clk;

  // attached return-address stack: push writes, pop presents data next cycle
  logic [ADDR_W-1:0] tb_mem [DEPTH];
  int                tb_sp;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      tb_sp     <= 0;
      stk_rdata <= '0;
    end else if (stk_push && tb_sp < DEPTH) begin
      tb_mem[tb_sp] <= stk_wdata;
      tb_sp         <= tb_sp + 1;
    end else if (stk_pop && tb_sp > 0) begin
      stk_rdata <= tb_mem[tb_sp-1];
      tb_sp     <= tb_sp - 1;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // drive inputs at a negedge, return at the next negedge (one posedge later)
  task automatic drive(input logic s, input logic c, input logic r, input logic j,
                       input logic [ADDR_W-1:0] t);
    step = s; is_call = c; is_ret = r; is_jmp = j; target = t;
    @(negedge clk);
  endtask

  task automatic do_reset;
    step = 0; is_call = 0; is_ret = 0; is_jmp = 0; target = '0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    do_reset;
    checks++;
    if ({pc, stk_push, stk_pop, stk_wdata, depth, busy, ovf_err, unf_err} !== '0) begin
      errors++;
      $display("FAIL reset_state: pc=%h push=%b pop=%b wdata=%h depth=%0d busy=%b ovf=%b unf=%b, want all 0",
               pc, stk_push, stk_pop, stk_wdata, depth, busy, ovf_err, unf_err);
    end
  endtask

  task automatic test_seq_pc;
    do_reset;
    for (int i = 1; i <= 5; i++) begin
      drive(1, 0, 0, 0, '0);
      checks++;
      if (pc !== ADDR_W'(i) || stk_push !== 1'b0 || stk_pop !== 1'b0) begin
        errors++;
        $display("FAIL seq_pc %0d: pc=%h push=%b pop=%b, want pc=%h strobes 0",
                 i, pc, stk_push, stk_pop, ADDR_W'(i));
      end
    end
  endtask

  task automatic test_call_ret;
    do_reset;
    drive(1, 0, 0, 1, 12'h010);
    checks++;
    if (pc !== 12'h010) begin errors++; $display("FAIL jmp_setup: pc=%h want 010", pc); end
    drive(1, 1, 0, 0, 12'h200);
    checks++;
    if (stk_push !== 1'b1 || stk_wdata !== 12'h011 || pc !== 12'h200 || depth !== DW'(1)) begin
      errors++;
      $display("FAIL call: push=%b wdata=%h pc=%h depth=%0d, want 1 011 200 1", stk_push, stk_wdata, pc, depth);
    end
    drive(0, 0, 0, 0, '0);
    checks++;
    if (stk_push !== 1'b0 || pc !== 12'h200) begin
      errors++; $display("FAIL call_strobe_drop: push=%b pc=%h, want 0 200", stk_push, pc);
    end
    drive(1, 0, 1, 0, '0);
    checks++;
    if (stk_pop !== 1'b1 || busy !== 1'b1 || depth !== DW'(0) || pc !== 12'h200) begin
      errors++;
      $display("FAIL ret_req: pop=%b busy=%b depth=%0d pc=%h, want 1 1 0 200", stk_pop, busy, depth, pc);
    end
    drive(0, 0, 0, 0, '0);
    checks++;
    if (stk_pop !== 1'b0 || busy !== 1'b1 || pc !== 12'h200) begin
      errors++; $display("FAIL ret_wait: pop=%b busy=%b pc=%h, want 0 1 200", stk_pop, busy, pc);
    end
    drive(0, 0, 0, 0, '0);
    checks++;
    if (busy !== 1'b0 || pc !== 12'h011 || depth !== DW'(0)) begin
      errors++; $display("FAIL ret_done: busy=%b pc=%h depth=%0d, want 0 011 0", busy, pc, depth);
    end
  endtask

  task automatic test_overflow;
    logic [ADDR_W-1:0] exp_w;
    do_reset;
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 1, 0, 0, ADDR_W'(12'h100 + i));
      exp_w = (i == 0) ? 12'h001 : ADDR_W'(12'h100 + i);
      checks++;
      if (stk_push !== 1'b1 || stk_wdata !== exp_w || depth !== DW'(i + 1) || pc !== ADDR_W'(12'h100 + i)) begin
        errors++;
        $display("FAIL fill_call %0d: push=%b wdata=%h depth=%0d pc=%h, want 1 %h %0d %h",
                 i, stk_push, stk_wdata, depth, pc, exp_w, i + 1, ADDR_W'(12'h100 + i));
      end
    end
    drive(1, 1, 0, 0, 12'h7FF);
    checks++;
    if (stk_push !== 1'b0 || ovf_err !== 1'b1 || pc !== 12'h107 || depth !== DW'(DEPTH)) begin
      errors++;
      $display("FAIL overflow: push=%b ovf=%b pc=%h depth=%0d, want 0 1 107 8", stk_push, ovf_err, pc, depth);
    end
    drive(1, 0, 0, 1, 12'h333);
    drive(1, 0, 1, 0, '0);
    drive(1, 0, 0, 0, '0);
    checks++;
    if (pc !== 12'h107 || depth !== DW'(DEPTH) || stk_push !== 1'b0 || stk_pop !== 1'b0 ||
        ovf_err !== 1'b1 || unf_err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL halt_frozen: pc=%h depth=%0d push=%b pop=%b ovf=%b unf=%b busy=%b, want 107 8 0 0 1 0 0",
               pc, depth, stk_push, stk_pop, ovf_err, unf_err, busy);
    end
    do_reset;
    checks++;
    if ({pc, depth, ovf_err, unf_err, busy} !== '0) begin
      errors++; $display("FAIL halt_reset: pc=%h depth=%0d ovf=%b, want 0", pc, depth, ovf_err);
    end
    drive(1, 0, 0, 0, '0);
    checks++;
    if (pc !== 12'h001) begin errors++; $display("FAIL post_halt_run: pc=%h want 001", pc); end
  endtask

  task automatic test_underflow;
    do_reset;
    drive(1, 0, 1, 0, '0);
    checks++;
    if (unf_err !== 1'b1 || stk_pop !== 1'b0 || pc !== 12'h000 || busy !== 1'b0) begin
      errors++; $display("FAIL underflow: unf=%b pop=%b pc=%h busy=%b, want 1 0 000 0", unf_err, stk_pop, pc, busy);
    end
    drive(1, 0, 0, 0, '0);
    checks++;
    if (unf_err !== 1'b1 || stk_pop !== 1'b0 || pc !== 12'h000) begin
      errors++; $display("FAIL underflow_halt: unf=%b pop=%b pc=%h, want 1 0 000", unf_err, stk_pop, pc);
    end
  endtask

  task automatic test_wrap;
    do_reset;
    drive(1, 0, 0, 1, 12'hFFF);
    drive(1, 1, 0, 0, 12'h100);
    checks++;
    if (stk_push !== 1'b1 || stk_wdata !== 12'h000 || pc !== 12'h100) begin
      errors++; $display("FAIL wrap_call: push=%b wdata=%h pc=%h, want 1 000 100", stk_push, stk_wdata, pc);
    end
    do_reset;
    drive(1, 0, 0, 1, 12'hFFF);
    drive(1, 0, 0, 0, '0);
    checks++;
    if (pc !== 12'h000) begin errors++; $display("FAIL wrap_pc: pc=%h want 000", pc); end
  endtask

  task automatic test_priority_busy_reset;
    do_reset;
    drive(1, 1, 1, 1, 12'h055);
    checks++;
    if (stk_push !== 1'b1 || stk_pop !== 1'b0 || stk_wdata !== 12'h001 || pc !== 12'h055 || depth !== DW'(1)) begin
      errors++;
      $display("FAIL priority: push=%b pop=%b wdata=%h pc=%h depth=%0d, want 1 0 001 055 1",
               stk_push, stk_pop, stk_wdata, pc, depth);
    end
    drive(1, 0, 1, 0, '0);
    drive(1, 0, 0, 1, 12'h3AA);   // step while busy: dropped
    checks++;
    if (busy !== 1'b1 || pc !== 12'h055 || stk_pop !== 1'b0) begin
      errors++; $display("FAIL busy_step1: busy=%b pc=%h pop=%b, want 1 055 0", busy, pc, stk_pop);
    end
    drive(1, 1, 0, 0, 12'h3AA);
    checks++;
    if (busy !== 1'b0 || pc !== 12'h001 || depth !== DW'(0) || stk_push !== 1'b0) begin
      errors++; $display("FAIL busy_step2: busy=%b pc=%h depth=%0d push=%b, want 0 001 0 0", busy, pc, depth, stk_push);
    end
    // reset landing in POP_WAIT must take effect without a clock edge
    drive(1, 1, 0, 0, 12'h123);
    drive(1, 0, 1, 0, '0);
    drive(0, 0, 0, 0, '0);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (pc !== 12'h000 || busy !== 1'b0 || depth !== DW'(0) || stk_pop !== 1'b0) begin
      errors++; $display("FAIL reset_in_wait: pc=%h busy=%b depth=%0d pop=%b, want 0 0 0 0", pc, busy, depth, stk_pop);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_random;
    logic [ADDR_W-1:0] m_pc, e_wdata, t;
    logic [ADDR_W-1:0] m_q[$];
    int                m_depth;
    logic              m_ovf, m_unf, m_halt, e_push, e_pop, e_busy, was_ret, s, c, r, j;
    do_reset;
    m_pc = '0; m_depth = 0; m_q.delete(); m_ovf = 0; m_unf = 0; m_halt = 0;
    for (int n = 0; n < 400; n++) begin
      s = ($urandom_range(0, 7) != 0);
      c = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 2) == 0);
      j = ($urandom_range(0, 1) == 1);
      t = ADDR_W'($urandom);
      e_push = 0; e_pop = 0; e_busy = 0; was_ret = 0; e_wdata = '0;
      if (s && !m_halt) begin
        if (c) begin
          if (m_depth < DEPTH) begin
            e_push = 1; e_wdata = m_pc + 12'd1; m_q.push_back(e_wdata);
            m_pc = t; m_depth++;
          end else begin m_ovf = 1; m_halt = 1; end
        end else if (r) begin
          if (m_depth > 0) begin e_pop = 1; e_busy = 1; m_depth--; was_ret = 1; end
          else begin m_unf = 1; m_halt = 1; end
        end else if (j) m_pc = t;
        else m_pc = m_pc + 12'd1;
      end
      drive(s, c, r, j, t);
      checks++;
      if ({pc, depth, stk_push, stk_pop, busy, ovf_err, unf_err} !==
          {m_pc, DW'(m_depth), e_push, e_pop, e_busy, m_ovf, m_unf}) begin
        errors++;
        $display("FAIL rand_op %0d: pc %h/%h depth %0d/%0d push %b/%b pop %b/%b busy %b/%b ovf %b/%b unf %b/%b (got/want)",
                 n, pc, m_pc, depth, m_depth, stk_push, e_push, stk_pop, e_pop, busy, e_busy, ovf_err, m_ovf, unf_err, m_unf);
      end
      if (e_push) begin
        checks++;
        if (stk_wdata !== e_wdata) begin
          errors++; $display("FAIL rand_wdata %0d: wdata=%h want %h", n, stk_wdata, e_wdata);
        end
      end
      if (was_ret) begin
        for (int k = 0; k < 2; k++) begin
          drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), ADDR_W'($urandom));
          if (k == 1) m_pc = m_q.pop_back();
          checks++;
          if ({pc, depth, stk_push, stk_pop, busy} !== {m_pc, DW'(m_depth), 1'b0, 1'b0, (k == 0)}) begin
            errors++;
            $display("FAIL rand_ret %0d.%0d: pc %h/%h depth %0d/%0d push %b pop %b busy %b (got/want)",
                     n, k, pc, m_pc, depth, m_depth, stk_push, stk_pop, busy);
          end
        end
      end
      if (m_halt && ($urandom_range(0, 1) == 1)) begin
        do_reset;
        m_pc = '0; m_depth = 0; m_q.delete(); m_ovf = 0; m_unf = 0; m_halt = 0;
      end
    end
  endtask

  initial begin
    rst = 1'b1; step = 0; is_call = 0; is_ret = 0; is_jmp = 0; target = '0;
    @(negedge clk);
    test_reset;
    test_seq_pc;
    test_call_ret;
    test_overflow;
    test_underflow;
    test_wrap;
    test_priority_busy_reset;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
